instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/pc_next_sel.sv | 43 ++++
 rtl/instr_fetch.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants, fetch FSM state type and address helpers
// Contents: XLEN, base opcode constants, fetch_state_t, word_align().
package riscv_pkg;

    localparam int XLEN = 32;

    // Base opcodes (instr[6:0]) consumed by main_decoder.
    localparam logic [6:0] OP_R      = 7'b011_0011;
    localparam logic [6:0] OP_I      = 7'b001_0011;
    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;

    // REQ   : request outstanding on the memory port
    // WAIT  : request accepted, waiting for its response
    // HOLD  : instruction buffered for decode
    // DRAIN : a response is still owed for a request that a flush cancelled
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    // Fetch addresses are always word aligned; low bits are simply dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next fetch address selection
// Ports:
//   pc, pc_plus4      : address of held instruction and its sequential successor
//   imm_ext           : sign-extended immediate of the held instruction
//   branch/zero/jump  : decoder/ALU redirect terms, only honoured when accept=1
//   flush, flush_pc   : redirect override, takes priority over everything
//   next_pc           : word-aligned next fetch address
module pc_next_sel
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic            accept,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] target;
    logic            pc_src;

    // Plain XLEN-bit adds: wrap-around past 2^32 is the intended behaviour.
    assign pc_plus4 = pc + 32'd4;
    assign target   = pc + imm_ext;

    // Branch/jump terms are meaningless except in the accept cycle, so they
    // are masked here rather than trusting the decoder to keep them quiet.
    assign pc_src = accept & ((branch & zero) | jump);

    always_comb begin
        next_pc = word_align(pc_plus4);
        if (flush) begin
            next_pc = word_align(flush_pc);
        end else if (pc_src) begin
            next_pc = word_align(target);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with decode hand-off
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr    : instruction memory request channel
//   imem_rsp_valid, imem_rsp_data      : instruction memory response channel
//   instr_valid/ready, instr, opcode   : held instruction towards decode
//   pc, pc_plus4                       : address of held instruction and +4
//   branch, zero, jump, imm_ext        : redirect inputs sampled on accept
//   flush, flush_pc                    : pipeline redirect
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            branch,
    input  logic            zero,
    input  logic            jump,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] next_pc;

    // Holds the request port quiet during reset and for the cycle up to the
    // first rising edge after release, so no handshake can happen while the
    // reset is still settling.
    logic            fetch_en;

    logic            accept;
    logic            capture;
    logic            load_fetch_pc;

    pc_next_sel u_pc_next_sel (
        .pc       (pc_q),
        .imm_ext  (imm_ext),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .accept   (accept),
        .flush    (flush),
        .flush_pc (flush_pc),
        .next_pc  (next_pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        capture       = 1'b0;
        load_fetch_pc = 1'b0;
        case (state)
            ST_REQ: begin
                if (flush) begin
                    load_fetch_pc = 1'b1;
                    // The old-address request still handshakes this cycle;
                    // its response must be thrown away.
                    if (fetch_en && imem_req_ready) begin
                        state_nxt = ST_DRAIN;
                    end
                end else if (fetch_en && imem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    load_fetch_pc = 1'b1;
                    // A response landing in the flush cycle already settles
                    // the cancelled request, so nothing is left to drain.
                    state_nxt = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Flush beats a coincident accept; redirect terms are dropped.
                if (flush) begin
                    load_fetch_pc = 1'b1;
                    state_nxt     = ST_REQ;
                end else if (instr_ready) begin
                    accept        = 1'b1;
                    load_fetch_pc = 1'b1;
                    state_nxt     = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    load_fetch_pc = 1'b1;
                end
                if (imem_rsp_valid) begin
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en <= 1'b0;
            fetch_pc <= RESET_PC;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
        end else begin
            fetch_en <= 1'b1;
            if (load_fetch_pc) begin
                fetch_pc <= next_pc;
            end
            // fetch_pc is untouched between request and response unless a
            // flush intervened, in which case nothing is captured.
            if (capture) begin
                instr_q <= imem_rsp_data;
                pc_q    <= fetch_pc;
            end
        end
    end

    assign imem_req_valid = fetch_en && (state == ST_REQ);
    assign imem_addr      = word_align(fetch_pc);
    assign instr_valid    = (state == ST_HOLD);
    assign instr          = instr_q;
    assign opcode         = instr_q[6:0];
    assign pc             = pc_q;

endmodule
